// File: rtl/jesd204b_tx_link_ctrl.sv
// jesd204b_tx_link_ctrl: JESD204B TX link sequencer (CGS/ILAS/DATA) with local LMFC for one lane.
// Optional JESD_TX_LINK_STATUS_EN adds resync_count and ilas_done status outputs.
module jesd204b_tx_link_ctrl #(
    parameter int LANE_DATA_WIDTH  = 32,
    parameter int OCTET_PER_SENT   = 4,
    parameter int OCTETS_PER_FR    = 2,
    parameter int FRAMES_PER_MF    = 10,
    parameter int ILAS_MF          = 4,
    parameter int SYNC_LOSS_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sync_n,
    input  logic [111:0]               in_config,
    input  logic [LANE_DATA_WIDTH-1:0] tx_data,
    output logic                       data_ready,
    output logic [LANE_DATA_WIDTH-1:0] lane_data,
    output logic [OCTET_PER_SENT-1:0]  charisk,
    output logic [1:0]                 link_state,
`ifdef JESD_TX_LINK_STATUS_EN
    output logic [7:0]                 resync_count,
    output logic                       ilas_done,
`endif
    output logic                       lmfc_pulse
);
    localparam int FK       = OCTETS_PER_FR * FRAMES_PER_MF;
    localparam int MF_BEATS = FK / OCTET_PER_SENT;
    localparam int CW       = MF_BEATS > 1 ? $clog2(MF_BEATS) : 1;
    localparam int MW       = ILAS_MF > 1 ? $clog2(ILAS_MF) : 1;
    localparam int LW       = SYNC_LOSS_CYCLES > 1 ? $clog2(SYNC_LOSS_CYCLES) : 1;

    typedef enum logic [1:0] {ST_CGS = 2'd0, ST_ILAS = 2'd1, ST_DATA = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q;
    logic [MW-1:0]              ilas_mf_q, ilas_mf_d;
    logic [LW-1:0]              low_q, low_d;
    logic                       sync_q, lmfc_q, last_beat, loss;
    logic [1:0]                 link_state_q;
    logic [LANE_DATA_WIDTH-1:0] lane_q, lane_d, ilas_lane;
    logic [OCTET_PER_SENT-1:0]  isk_q, isk_d, ilas_isk;

    // {is_k, octet} for ILAS octet o of a multiframe; mf1 selects the config-carrying multiframe
    function automatic logic [8:0] ilas_octet(input int o, input logic mf1, input logic [111:0] cfg);
        return o == 0                          ? {1'b1, 8'h1C} :
               o == FK - 1                     ? {1'b1, 8'h7C} :
               mf1 && o == 1                   ? {1'b1, 8'h9C} :
               mf1 && o >= 2 && o <= 15        ? {1'b0, cfg[8*(15-o) +: 8]} :
                                                 {1'b0, o[7:0]};
    endfunction

    assign last_beat  = cnt_q == CW'(MF_BEATS - 1);
    assign loss       = state_q != ST_CGS && !sync_q && low_q == LW'(SYNC_LOSS_CYCLES - 1);
    assign data_ready = state_q == ST_DATA;
    assign lane_data  = lane_q;
    assign charisk    = isk_q;
    assign link_state = link_state_q;
    assign lmfc_pulse = lmfc_q;

    always_comb begin
        state_d   = state_q;
        ilas_mf_d = ilas_mf_q;
        low_d     = (state_q == ST_CGS || sync_q || loss) ? '0 : low_q + LW'(1);
        if (loss) begin
            state_d = ST_CGS;
        end else if (state_q == ST_CGS && last_beat && sync_q) begin
            state_d   = ST_ILAS;
            ilas_mf_d = '0;
        end else if (state_q == ST_ILAS && last_beat) begin
            state_d   = ilas_mf_q == MW'(ILAS_MF - 1) ? ST_DATA : ST_ILAS;
            ilas_mf_d = ilas_mf_q + MW'(1);
        end
    end

    always_comb begin
        ilas_lane = '0;
        ilas_isk  = '0;
        for (int i = 0; i < OCTET_PER_SENT; i++)
            {ilas_isk[OCTET_PER_SENT-1-i], ilas_lane[LANE_DATA_WIDTH-1-8*i -: 8]} =
                ilas_octet(int'(cnt_q) * OCTET_PER_SENT + i, ilas_mf_q == MW'(1), in_config);
        lane_d = state_q == ST_DATA ? tx_data : state_q == ST_ILAS ? ilas_lane : {OCTET_PER_SENT{8'hBC}};
        isk_d  = state_q == ST_ILAS ? ilas_isk : {OCTET_PER_SENT{state_q == ST_CGS}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CGS;
            cnt_q        <= '0;
            ilas_mf_q    <= '0;
            low_q        <= '0;
            sync_q       <= 1'b0;
            lane_q       <= {OCTET_PER_SENT{8'hBC}};
            isk_q        <= '1;
            link_state_q <= 2'd0;
            lmfc_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= last_beat ? '0 : cnt_q + CW'(1);
            ilas_mf_q    <= ilas_mf_d;
            low_q        <= low_d;
            sync_q       <= sync_n;
            lane_q       <= lane_d;
            isk_q        <= isk_d;
            link_state_q <= state_q;
            lmfc_q       <= cnt_q == '0;
        end
    end

`ifdef JESD_TX_LINK_STATUS_EN
    logic [7:0] resync_q;
    logic       ilas_done_q;

    assign resync_count = resync_q;
    assign ilas_done    = ilas_done_q;

    // DATA is only entered from ILAS, so a DATA beat following a non-DATA beat is the first one
    always_ff @(posedge clk) begin
        if (reset) begin
            resync_q    <= '0;
            ilas_done_q <= 1'b0;
        end else begin
            resync_q    <= (loss && resync_q != 8'hFF) ? resync_q + 8'd1 : resync_q;
            ilas_done_q <= state_q == ST_DATA && link_state_q != 2'd2;
        end
    end
`endif
endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// tb_jesd204b_tx_link_ctrl: directed bench with an octet-level link model checked every cycle.
module tb_jesd204b_tx_link_ctrl;
    localparam int OPS = 4, FK = 20, MFB = 5, ILAS_MF = 4, SLC = 2;

    logic         clk = 1'b0, reset = 1'b1, sync_n = 1'b0;
    logic [111:0] in_config = 112'h7777777788888888777777778888;
    logic [31:0]  tx_data = '0;
    logic         data_ready, lmfc_pulse;
    logic [31:0]  lane_data;
    logic [3:0]   charisk;
    logic [1:0]   link_state;
`ifdef JESD_TX_LINK_STATUS_EN
    logic [7:0]   resync_count;
    logic         ilas_done;
`endif

    jesd204b_tx_link_ctrl dut (
        .clk(clk), .reset(reset), .sync_n(sync_n), .in_config(in_config), .tx_data(tx_data),
        .data_ready(data_ready), .lane_data(lane_data), .charisk(charisk), .link_state(link_state),
`ifdef JESD_TX_LINK_STATUS_EN
        .resync_count(resync_count), .ilas_done(ilas_done),
`endif
        .lmfc_pulse(lmfc_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: beats counted since reset, ILAS progress as an octet count, sync history as a low-run length
    int          nbeat, mst, mrun, ioct, m_tag, e_rc;
    logic        msq, m_loss, e_valid = 1'b0, e_lmfc, e_ready, e_done;
    logic [31:0] e_lane;
    logic [3:0]  e_isk;
    logic [1:0]  e_link;
    logic [8:0]  m_oc;

    function automatic logic [8:0] m_ilas(input int o, input int mf, input logic [111:0] cfg);
        if (o == 0) return {1'b1, 8'h1C};
        if (o == FK - 1) return {1'b1, 8'h7C};
        if (mf == 1 && o == 1) return {1'b1, 8'h9C};
        if (mf == 1 && o >= 2 && o <= 15) return {1'b0, cfg[111-8*(o-2) -: 8]};
        return {1'b0, 8'(o)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            nbeat = 0; mst = 0; mrun = 0; ioct = 0; msq = 1'b0; e_rc = 0;
            e_lane = 32'hBCBCBCBC; e_isk = 4'hF; e_link = 2'd0; e_lmfc = 1'b0; e_ready = 1'b0; e_done = 1'b0;
            e_valid = 1'b1;
        end else begin
            m_tag  = nbeat % MFB;
            e_done = mst == 2 && e_link != 2'd2;
            e_lmfc = m_tag == 0;
            e_link = 2'(mst);
            if (mst == 0) begin
                e_lane = 32'hBCBCBCBC; e_isk = 4'hF;
            end else if (mst == 1) begin
                for (int k = 0; k < OPS; k++) begin
                    m_oc = m_ilas(ioct % FK + k, ioct / FK, in_config);
                    e_isk[3-k] = m_oc[8];
                    e_lane[31-8*k -: 8] = m_oc[7:0];
                end
            end else begin
                e_lane = tx_data; e_isk = 4'h0;
            end
            m_loss = mst != 0 && !msq && mrun + 1 >= SLC;
            mrun   = (mst == 0 || msq || m_loss) ? 0 : mrun + 1;
            if (mst == 1) ioct += OPS;
            if (m_loss) begin
                mst = 0;
                if (e_rc < 255) e_rc++;
            end else if (mst == 0 && m_tag == MFB - 1 && msq) begin
                mst = 1; ioct = 0;
            end else if (mst == 1 && ioct == ILAS_MF * FK) begin
                mst = 2;
            end
            msq = sync_n;
            nbeat++;
            e_ready = mst == 2;
        end
    end

    always @(negedge clk) begin
        if (e_valid) begin
            chk("m_lane_data", lane_data, e_lane);
            chk("m_charisk", 32'(charisk), 32'(e_isk));
            chk("m_link_state", 32'(link_state), 32'(e_link));
            chk("m_lmfc_pulse", 32'(lmfc_pulse), 32'(e_lmfc));
            chk("m_data_ready", 32'(data_ready), 32'(e_ready));
`ifdef JESD_TX_LINK_STATUS_EN
            chk("m_resync_count", 32'(resync_count), 32'(e_rc));
            chk("m_ilas_done", 32'(ilas_done), 32'(e_done));
`endif
        end
    end

    task automatic wait_for(input logic on_ready, input logic [1:0] v, input string name);
        int n = 0;
        while ((on_ready ? data_ready !== 1'b1 : link_state !== v) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (on_ready ? data_ready !== 1'b1 : link_state !== v) begin
            errors++;
            $display("FAIL %s: timed out, link_state=%0d data_ready=%b", name, link_state, data_ready);
        end
    endtask

    logic [31:0] mf1_lane [5] = '{32'h1C9C7777, 32'h77778888, 32'h88887777, 32'h77778888, 32'h1011127C};
    logic [3:0]  mf1_isk  [5] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lane", lane_data, 32'hBCBCBCBC);
        chk("rst_isk", 32'(charisk), 32'hF);
        chk("rst_link", 32'(link_state), 0);
        chk("rst_ready", 32'(data_ready), 0);
        chk("rst_lmfc", 32'(lmfc_pulse), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_beat_lmfc", 32'(lmfc_pulse), 1);
        @(negedge clk);
        sync_n = 1'b1;
        wait_for(1'b0, 2'd1, "cgs_to_ilas");
        chk("ilas0_lane", lane_data, 32'h1C010203);
        chk("ilas0_isk", 32'(charisk), 32'h8);
        chk("ilas0_lmfc", 32'(lmfc_pulse), 1);
        @(negedge clk);
        chk("ilas1_lane", lane_data, 32'h04050607);
        repeat (4) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("mf1_lane%0d", b), lane_data, mf1_lane[b]);
            chk($sformatf("mf1_isk%0d", b), 32'(charisk), 32'(mf1_isk[b]));
            @(negedge clk);
        end
        wait_for(1'b1, 2'd0, "ilas_to_data");
        chk("last_ilas_lane", lane_data, 32'h1011127C);
        chk("last_ilas_link", 32'(link_state), 1);
        tx_data = 32'h11111111;
        @(negedge clk);
        chk("data0_lane", lane_data, 32'h11111111);
        chk("data0_isk", 32'(charisk), 0);
        chk("data0_lmfc", 32'(lmfc_pulse), 1);
        chk("data0_link", 32'(link_state), 2);
        tx_data = 32'h22222222;
        @(negedge clk);
        chk("data1_lane", lane_data, 32'h22222222);
        sync_n = 1'b0;
        @(negedge clk);
        sync_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_link", 32'(link_state), 2);
        chk("glitch_ready", 32'(data_ready), 1);
        sync_n = 1'b0;
        repeat (2) @(negedge clk);
        sync_n = 1'b1;
        wait_for(1'b0, 2'd0, "loss_to_cgs");
        chk("loss_lane", lane_data, 32'hBCBCBCBC);
        chk("loss_isk", 32'(charisk), 32'hF);
        chk("loss_ready", 32'(data_ready), 0);
        wait_for(1'b0, 2'd1, "resync_ilas");
        chk("resync_lmfc", 32'(lmfc_pulse), 1);
        chk("resync_lane", lane_data, 32'h1C010203);
        repeat (7) @(negedge clk);
        chk("mid_ilas_lane", lane_data, 32'h88887777);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_lane", lane_data, 32'hBCBCBCBC);
        chk("midrst_link", 32'(link_state), 0);
        chk("midrst_lmfc", 32'(lmfc_pulse), 0);
        reset = 1'b0;
`ifdef JESD_TX_LINK_STATUS_EN
        chk("midrst_resync", 32'(resync_count), 0);
        for (int n = 0; n < 300; n++) begin
            wait_for(1'b0, 2'd1, "sat_ilas");
            sync_n = 1'b0;
            repeat (3) @(negedge clk);
            sync_n = 1'b1;
            wait_for(1'b0, 2'd0, "sat_cgs");
        end
        chk("resync_saturated", 32'(resync_count), 255);
`endif
        wait_for(1'b1, 2'd0, "final_data");
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
